vga_decoder: RTL and testbench
==============================

// Module: vga_decoder
// PURPOSE
//  Receive end of the pong video link: samples hsync/vsync/rrggbb on the pixel clock and recovers pixel coordinates.
//  Decodes the 16x16-cell play area back into ball position and paddle bitmaps; checks frame timing and reports lock.
//  Used for loopback self-test and in the verification harness against the video generator.
// PARAMETERS
//  H_TOTAL  832  pixel clocks per line (hsync assertion to hsync assertion)
//  V_TOTAL  520  lines per frame (vsync assertion to vsync assertion)
//  H_START  168  clocks from hsync assertion to first active pixel (x_px=0)
//  V_START  31   lines from vsync assertion to first active line (y_px=0)
// PORTS
//  clk          in   1   pixel clock (31.5 MHz); hsync/vsync/rrggbb are synchronous to it
//  reset        in   1   asynchronous, active-low
//  hsync        in   1   horizontal sync, active-low
//  vsync        in   1   vertical sync, active-low
//  rrggbb       in   6   pixel colour
//  ball_x       out  4   decoded ball column
//  ball_y       out  4   decoded ball row
//  ball_valid   out  1   exactly one ball cell found in last good frame
//  multi_ball   out  1   more than one ball cell found in last good frame
//  lpaddle      out  16  bit r set = cell (col 15, row r) white
//  rpaddle      out  16  bit r set = cell (col 0, row r) white
//  locked       out  1   timing matched on the last two consecutive frames
//  frame_strobe out  1   one-cycle pulse: outputs just committed from a good frame
//  frame_err    out  1   one-cycle pulse: frame ended with a timing error
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0; counters 0; shadow regs cleared; seen_vsync=0; good_cnt=0.
//  Edge detect: hs_prev/vs_prev registered; assertion = prev 1 and current 0.
//  x_cnt: 0 in the hsync assertion cycle, else +1, saturating at 1023. y_cnt: +1 at each hsync assertion, saturating at 1023.
//  At vsync assertion, y_cnt is forced to 0; vsync wins over a simultaneous hsync.
//  x_px = x_cnt-H_START, y_px = y_cnt-V_START; active only when x_cnt>=H_START and y_cnt>=V_START.
//  Sample point: active, x_px<256, y_px<256, x_px[3:0]==8, y_px[3:0]==8; cell=(x_px[7:4],y_px[7:4]).
//  A sample is white only when rrggbb==6'b111111.
//  White at col 15 -> lpaddle_sh[row]=1; col 0 -> rpaddle_sh[row]=1; col 1..14 -> ball_cnt++ (saturates at 2), ball_sh=cell.
//  Ball cells in col 0/15 are indistinguishable from paddles; they are reported as paddle bits.
//  Line check: at each hsync assertion after the first of the frame, x_cnt+1 != H_TOTAL sets sticky line_err.
//  Frame end (vsync assertion, seen_vsync=1): good = !line_err && y_cnt+1==V_TOTAL.
//   good: copy shadows to outputs next cycle.
//    ball_valid=(ball_cnt==1); multi_ball=(ball_cnt==2); ball_x/y=ball_sh only if ball_cnt==1, else held.
//    frame_strobe=1 for one cycle; good_cnt saturates at 2; locked=(good_cnt==2).
//   bad: outputs held; frame_err=1 for one cycle; good_cnt=0; locked=0 the same cycle frame_err asserts.
//   Either case: shadows, ball_cnt and line_err are cleared for the new frame.
//  First vsync after reset only sets seen_vsync: no commit, no strobe, no error.
//  Latency: frame_strobe/frame_err and updated outputs appear 1 clk after the vsync-assertion cycle.
//  Counter saturation (sync lost): line length/line count mismatches and the frame is flagged bad at the next vsync.
//  No vsync ever: outputs stay at reset values.
// CONFIGURATION
//  VGA_DECODER_BGCOLOR_EN defined: adds output bgcolor[2:0].
//   Captured at active x_px==8, y_px==8 (cell 0,0 centre), but only when that pixel is not white.
//   Value is {rrggbb[5],rrggbb[3],rrggbb[1]}; committed with the other outputs on good frames; reset 0.
//  Not defined: no bgcolor port and no capture logic; all other behaviour is identical.
// TESTING
//  T1 reset=0 asserted mid-frame, released -> all outputs 0 at once; first good frame after 2 vsyncs gives strobe, locked only after 3.
//  T2 generator: ball (5,7), lpaddle 16'h00F0, rpaddle 16'h0F00, 4 frames.
//   -> ball_x=5, ball_y=7, ball_valid=1, lpaddle=16'h00F0, rpaddle=16'h0F00; locked=1 from the 3rd vsync commit.
//  T3 while locked, one line shortened to 800 clocks -> frame_err pulse at the next vsync, locked=0, outputs unchanged.
//   -> locked returns after 2 further good frames.
//  T4 white cells at (3,3) and (9,9) -> ball_valid=0, multi_ball=1, ball_x/y hold previous values.
//  T5 ball at (15,4) with lpaddle=0 -> lpaddle=16'h0010, ball_valid=0, multi_ball=0.
//  T6 (VGA_DECODER_BGCOLOR_EN) background rrggbb=6'b100010 at cell (0,0) -> bgcolor=3'b101 after the commit.

Source files
------------

// File: rtl/vga_decoder_if.sv
// Video link bundle between the pong generator (master) and the receive decoder (slave).
// VGA_DECODER_BGCOLOR_EN adds the decoded background colour to the bundle.
interface vga_decoder_if;
  logic        hsync;
  logic        vsync;
  logic [5:0]  rrggbb;
  logic [3:0]  ball_x;
  logic [3:0]  ball_y;
  logic        ball_valid;
  logic        multi_ball;
  logic [15:0] lpaddle;
  logic [15:0] rpaddle;
  logic        locked;
  logic        frame_strobe;
  logic        frame_err;
`ifdef VGA_DECODER_BGCOLOR_EN
  logic [2:0]  bgcolor;

  modport master (
    output hsync, vsync, rrggbb,
    input  ball_x, ball_y, ball_valid, multi_ball, lpaddle, rpaddle,
    input  locked, frame_strobe, frame_err, bgcolor
  );

  modport slave (
    input  hsync, vsync, rrggbb,
    output ball_x, ball_y, ball_valid, multi_ball, lpaddle, rpaddle,
    output locked, frame_strobe, frame_err, bgcolor
  );
`else
  modport master (
    output hsync, vsync, rrggbb,
    input  ball_x, ball_y, ball_valid, multi_ball, lpaddle, rpaddle,
    input  locked, frame_strobe, frame_err
  );

  modport slave (
    input  hsync, vsync, rrggbb,
    output ball_x, ball_y, ball_valid, multi_ball, lpaddle, rpaddle,
    output locked, frame_strobe, frame_err
  );
`endif
endinterface

// File: rtl/vga_decoder.sv
// Pong video receiver: recovers pixel position, decodes the 16x16 cell play area, checks frame timing.
// Optional VGA_DECODER_BGCOLOR_EN: also reports the background colour sampled at cell (0,0).
module vga_decoder #(
  parameter int H_TOTAL = 832,
  parameter int V_TOTAL = 520,
  parameter int H_START = 168,
  parameter int V_START = 31
) (
  input  logic         clk,
  input  logic         reset,
  vga_decoder_if.slave vid
);

  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [9:0]  H_ST    = 10'(H_START);
  localparam logic [9:0]  V_ST    = 10'(V_START);
  localparam logic [10:0] H_LEN   = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN   = 11'(V_TOTAL);

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd2 : v + 2'd1;
  endfunction

  logic        hs_prev, vs_prev, hs_fall, vs_fall;
  logic [9:0]  x_q, y_q, x_pos, y_pos, x_px, y_px;
  logic        active, sample, white;
  logic [3:0]  cell_x, cell_y;
  logic        hs_seen, seen_vsync, line_err, line_bad, frame_good;
  logic [1:0]  ball_cnt, good_cnt;
  logic [3:0]  ball_x_sh, ball_y_sh;
  logic [15:0] lp_sh, rp_sh;
  logic [3:0]  ball_x_r, ball_y_r;
  logic        ball_valid_r, multi_ball_r, locked_r, strobe_r, err_r;
  logic [15:0] lp_r, rp_r;

  assign hs_fall = hs_prev & ~vid.hsync;
  assign vs_fall = vs_prev & ~vid.vsync;

  // Position of the current cycle: x restarts on the hsync edge, y on the vsync edge.
  always_comb begin
    x_pos = hs_fall ? 10'd0 : sat_inc10(x_q);
    y_pos = y_q;
    if (vs_fall)
      y_pos = 10'd0;
    else if (hs_fall)
      y_pos = sat_inc10(y_q);
  end

  assign x_px   = x_pos - H_ST;
  assign y_px   = y_pos - V_ST;
  assign active = (x_pos >= H_ST) && (y_pos >= V_ST);
  assign sample = active && (x_px < 10'd256) && (y_px < 10'd256) &&
                  (x_px[3:0] == 4'd8) && (y_px[3:0] == 4'd8);
  assign cell_x = x_px[7:4];
  assign cell_y = y_px[7:4];
  assign white  = (vid.rrggbb == 6'b111111);

  // x_q/y_q hold the previous cycle's position, so +1 gives the length just ended.
  assign line_bad   = hs_fall && hs_seen && !vs_fall && (({1'b0, x_q} + 11'd1) != H_LEN);
  assign frame_good = !line_err && (({1'b0, y_q} + 11'd1) == V_LEN);

`ifdef VGA_DECODER_BGCOLOR_EN
  logic [2:0] bg_sh, bg_r;
  assign vid.bgcolor = bg_r;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_prev      <= 1'b0;
      vs_prev      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      hs_seen      <= 1'b0;
      seen_vsync   <= 1'b0;
      line_err     <= 1'b0;
      ball_cnt     <= '0;
      good_cnt     <= '0;
      ball_x_sh    <= '0;
      ball_y_sh    <= '0;
      lp_sh        <= '0;
      rp_sh        <= '0;
      ball_x_r     <= '0;
      ball_y_r     <= '0;
      ball_valid_r <= 1'b0;
      multi_ball_r <= 1'b0;
      lp_r         <= '0;
      rp_r         <= '0;
      locked_r     <= 1'b0;
      strobe_r     <= 1'b0;
      err_r        <= 1'b0;
`ifdef VGA_DECODER_BGCOLOR_EN
      bg_sh        <= '0;
      bg_r         <= '0;
`endif
    end else begin
      hs_prev  <= vid.hsync;
      vs_prev  <= vid.vsync;
      x_q      <= x_pos;
      y_q      <= y_pos;
      strobe_r <= 1'b0;
      err_r    <= 1'b0;

      if (vs_fall)
        hs_seen <= hs_fall;
      else if (hs_fall)
        hs_seen <= 1'b1;

      if (line_bad)
        line_err <= 1'b1;

      // Edge columns belong to the paddles, even if the ball sits there.
      if (sample && white) begin
        if (cell_x == 4'd15)
          lp_sh[cell_y] <= 1'b1;
        else if (cell_x == 4'd0)
          rp_sh[cell_y] <= 1'b1;
        else begin
          ball_cnt  <= sat_inc2(ball_cnt);
          ball_x_sh <= cell_x;
          ball_y_sh <= cell_y;
        end
      end

`ifdef VGA_DECODER_BGCOLOR_EN
      if (sample && !white && (cell_x == 4'd0) && (cell_y == 4'd0))
        bg_sh <= {vid.rrggbb[5], vid.rrggbb[3], vid.rrggbb[1]};
`endif

      if (vs_fall) begin
        seen_vsync <= 1'b1;
        if (seen_vsync) begin
          if (frame_good) begin
            ball_valid_r <= (ball_cnt == 2'd1);
            multi_ball_r <= (ball_cnt == 2'd2);
            if (ball_cnt == 2'd1) begin
              ball_x_r <= ball_x_sh;
              ball_y_r <= ball_y_sh;
            end
            lp_r     <= lp_sh;
            rp_r     <= rp_sh;
            strobe_r <= 1'b1;
            good_cnt <= sat_inc2(good_cnt);
            locked_r <= (sat_inc2(good_cnt) == 2'd2);
`ifdef VGA_DECODER_BGCOLOR_EN
            bg_r     <= bg_sh;
`endif
          end else begin
            err_r    <= 1'b1;
            good_cnt <= '0;
            locked_r <= 1'b0;
          end
        end
        ball_cnt  <= '0;
        ball_x_sh <= '0;
        ball_y_sh <= '0;
        lp_sh     <= '0;
        rp_sh     <= '0;
        line_err  <= 1'b0;
`ifdef VGA_DECODER_BGCOLOR_EN
        bg_sh     <= '0;
`endif
      end
    end
  end

  assign vid.ball_x       = ball_x_r;
  assign vid.ball_y       = ball_y_r;
  assign vid.ball_valid   = ball_valid_r;
  assign vid.multi_ball   = multi_ball_r;
  assign vid.lpaddle      = lp_r;
  assign vid.rpaddle      = rp_r;
  assign vid.locked       = locked_r;
  assign vid.frame_strobe = strobe_r;
  assign vid.frame_err    = err_r;

endmodule

// File: tb/tb_vga_decoder.sv
// Directed bench for vga_decoder: a reduced-size frame generator drives cell patterns and timing faults.
module tb_vga_decoder;

  localparam int HT = 252;
  localparam int VT = 28;
  localparam int HS = 2;
  localparam int VS = 1;

  localparam logic [31:0] PAT_A = 32'h0021_8000;  // ball (5,1), lpaddle row 0, rpaddle row 1
  localparam logic [31:0] PAT_B = 32'h0200_0008;  // white cells (3,0) and (9,1)
  localparam logic [31:0] PAT_C = 32'h8000_0000;  // ball in column 15, row 1

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_decoder_if vif();

  vga_decoder #(.H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS)) dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vif)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_strobe = 0;
  int n_ferr = 0;

  logic        s_strobe, s_err, s_valid, s_multi, s_locked;
  logic [3:0]  s_bx, s_by;
  logic [15:0] s_lp, s_rp;
  logic [2:0]  s_bg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vif.frame_strobe === 1'b1) n_strobe++;
    if (vif.frame_err === 1'b1) n_ferr++;
  end

  function automatic logic [5:0] pix(input logic [31:0] mask, input int l, input int p);
    int xp, yp, idx;
    xp = p - HS;
    yp = l - VS;
    if (xp >= 0 && xp < 256 && yp >= 0 && yp < 32) begin
      idx = (yp / 16) * 16 + (xp / 16);
      if (mask[idx]) return 6'b111111;
    end
    return 6'b100010;
  endfunction

  task automatic snapshot();
    s_strobe = vif.frame_strobe;
    s_err    = vif.frame_err;
    s_valid  = vif.ball_valid;
    s_multi  = vif.multi_ball;
    s_locked = vif.locked;
    s_bx     = vif.ball_x;
    s_by     = vif.ball_y;
    s_lp     = vif.lpaddle;
    s_rp     = vif.rpaddle;
`ifdef VGA_DECODER_BGCOLOR_EN
    s_bg     = vif.bgcolor;
`else
    s_bg     = 3'b000;
`endif
  endtask

  // One frame starting with the vsync edge; outputs are captured one cycle after that edge.
  task automatic send_frame(input logic [31:0] mask, input int n_lines,
                            input int short_line, input int rst_line);
    int len;
    for (int l = 0; l < n_lines; l++) begin
      len = (l == short_line) ? 200 : HT;
      for (int p = 0; p < len; p++) begin
        @(negedge clk);
        if (l == 0 && p == 1) snapshot();
        vif.hsync  = (p < 4) ? 1'b0 : 1'b1;
        vif.vsync  = (l < 2) ? 1'b0 : 1'b1;
        vif.rrggbb = pix(mask, l, p);
        if (l == rst_line && p == 100) begin
          reset = 1'b0;
          #1;
          check("midrst_valid", 32'(vif.ball_valid), 32'd0);
          check("midrst_bx", 32'(vif.ball_x), 32'd0);
          check("midrst_lp", 32'(vif.lpaddle), 32'd0);
          check("midrst_rp", 32'(vif.rpaddle), 32'd0);
          check("midrst_locked", 32'(vif.locked), 32'd0);
          #1;
          reset = 1'b1;
        end
      end
    end
  endtask

  initial begin
    vif.hsync  = 1'b1;
    vif.vsync  = 1'b1;
    vif.rrggbb = 6'b000000;
    repeat (3) @(negedge clk);
    check("rst_bx", 32'(vif.ball_x), 32'd0);
    check("rst_by", 32'(vif.ball_y), 32'd0);
    check("rst_valid", 32'(vif.ball_valid), 32'd0);
    check("rst_multi", 32'(vif.multi_ball), 32'd0);
    check("rst_lp", 32'(vif.lpaddle), 32'd0);
    check("rst_rp", 32'(vif.rpaddle), 32'd0);
    check("rst_locked", 32'(vif.locked), 32'd0);
    check("rst_strobe", 32'(vif.frame_strobe), 32'd0);
    check("rst_err", 32'(vif.frame_err), 32'd0);
`ifdef VGA_DECODER_BGCOLOR_EN
    check("rst_bg", 32'(vif.bgcolor), 32'd0);
`endif
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // v1: first vsync only arms the checker
    send_frame(PAT_A, VT, -1, -1);
    check("v1_strobe", 32'(s_strobe), 32'd0);
    check("v1_err", 32'(s_err), 32'd0);
    check("v1_valid", 32'(s_valid), 32'd0);

    // v2: first commit, not yet locked
    send_frame(PAT_A, VT, -1, -1);
    check("v2_strobe", 32'(s_strobe), 32'd1);
    check("v2_locked", 32'(s_locked), 32'd0);
    check("v2_bx", 32'(s_bx), 32'd5);
    check("v2_by", 32'(s_by), 32'd1);
    check("v2_valid", 32'(s_valid), 32'd1);
    check("v2_multi", 32'(s_multi), 32'd0);
    check("v2_lp", 32'(s_lp), 32'h0001);
    check("v2_rp", 32'(s_rp), 32'h0002);
`ifdef VGA_DECODER_BGCOLOR_EN
    check("v2_bg", 32'(s_bg), 32'b101);
`endif

    // v3: locked; reset pulsed in the middle of the following frame
    send_frame(PAT_A, VT, -1, 12);
    check("v3_strobe", 32'(s_strobe), 32'd1);
    check("v3_locked", 32'(s_locked), 32'd1);

    // v4: first vsync after reset, no commit
    send_frame(PAT_A, VT, -1, -1);
    check("v4_strobe", 32'(s_strobe), 32'd0);
    check("v4_err", 32'(s_err), 32'd0);
    check("v4_valid", 32'(s_valid), 32'd0);
    check("v4_lp", 32'(s_lp), 32'h0000);

    // v5: commit again, relock pending; next frame has one short line
    send_frame(PAT_A, VT, -1, -1);
    check("v5_strobe", 32'(s_strobe), 32'd1);
    check("v5_locked", 32'(s_locked), 32'd0);
    check("v5_valid", 32'(s_valid), 32'd1);
    check("v5_bx", 32'(s_bx), 32'd5);

    send_frame(PAT_A, VT, 10, -1);
    check("v6_strobe", 32'(s_strobe), 32'd1);
    check("v6_locked", 32'(s_locked), 32'd1);

    // v7: bad frame, outputs held
    send_frame(PAT_B, VT, -1, -1);
    check("v7_err", 32'(s_err), 32'd1);
    check("v7_strobe", 32'(s_strobe), 32'd0);
    check("v7_locked", 32'(s_locked), 32'd0);
    check("v7_valid", 32'(s_valid), 32'd1);
    check("v7_bx", 32'(s_bx), 32'd5);
    check("v7_by", 32'(s_by), 32'd1);
    check("v7_lp", 32'(s_lp), 32'h0001);
    check("v7_rp", 32'(s_rp), 32'h0002);

    // v8: two ball cells
    send_frame(PAT_C, VT, -1, -1);
    check("v8_strobe", 32'(s_strobe), 32'd1);
    check("v8_locked", 32'(s_locked), 32'd0);
    check("v8_multi", 32'(s_multi), 32'd1);
    check("v8_valid", 32'(s_valid), 32'd0);
    check("v8_bx", 32'(s_bx), 32'd5);
    check("v8_by", 32'(s_by), 32'd1);
    check("v8_lp", 32'(s_lp), 32'h0000);
    check("v8_rp", 32'(s_rp), 32'h0000);
`ifdef VGA_DECODER_BGCOLOR_EN
    check("v8_bg", 32'(s_bg), 32'b101);
`endif

    // v9: ball in column 15 reads as paddle; lock restored
    send_frame(PAT_A, 1, -1, -1);
    check("v9_strobe", 32'(s_strobe), 32'd1);
    check("v9_locked", 32'(s_locked), 32'd1);
    check("v9_lp", 32'(s_lp), 32'h0002);
    check("v9_rp", 32'(s_rp), 32'h0000);
    check("v9_valid", 32'(s_valid), 32'd0);
    check("v9_multi", 32'(s_multi), 32'd0);
    check("v9_bx", 32'(s_bx), 32'd5);

    repeat (4) @(negedge clk);
    check("strobe_count", 32'(n_strobe), 32'd6);
    check("err_count", 32'(n_ferr), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
